// File: rtl/des_tx_arbiter.sv
// Two-way round-robin arbiter feeding the RS232 byte channel: captures the granted
// 64-bit word and emits it LSB byte first, one strobe every BYTE_GAP+1 cycles.
module des_tx_arbiter #(
    parameter int BYTE_GAP = 6944,
    parameter int GAP_W    = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0,
    input  logic [63:0] DATA0,
    input  logic        REQ1,
    input  logic [63:0] DATA1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [7:0]  SEND_DATA,
    output logic        SEND_DATA_READY,
    output logic        BUSY,
    output logic        ACTIVE_SRC
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(BYTE_GAP - 1);
    localparam logic [3:0]       LAST_BYTE = 4'd8;

    logic [1:0]       stateReg;
    logic             lastServedReg;
    logic [3:0]       byteCntReg;
    logic [GAP_W-1:0] gapCntReg;
    logic [63:0]      shiftReg;

    logic [1:0] reqVec;
    logic [1:0] winVec;
    logic       grantAny;
    logic       grantSel;

    assign reqVec = {REQ1, REQ0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_win
            // Alone wins outright; on a tie the requester not served last wins.
            assign winVec[gi] = reqVec[gi] & (~reqVec[1-gi] | (lastServedReg != 1'(gi)));
        end
    endgenerate

    assign grantAny = |winVec;
    assign grantSel = winVec[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stateReg        <= IDLE;
            lastServedReg   <= 1'b1;
            byteCntReg      <= 4'd0;
            gapCntReg       <= '0;
            shiftReg        <= 64'd0;
            GNT0            <= 1'b0;
            GNT1            <= 1'b0;
            DONE0           <= 1'b0;
            DONE1           <= 1'b0;
            SEND_DATA       <= 8'd0;
            SEND_DATA_READY <= 1'b0;
            BUSY            <= 1'b0;
            ACTIVE_SRC      <= 1'b0;
        end else begin
            GNT0            <= 1'b0;
            GNT1            <= 1'b0;
            DONE0           <= 1'b0;
            DONE1           <= 1'b0;
            SEND_DATA_READY <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (grantAny) begin
                        shiftReg   <= grantSel ? DATA1 : DATA0;
                        GNT0       <= ~grantSel;
                        GNT1       <= grantSel;
                        ACTIVE_SRC <= grantSel;
                        byteCntReg <= 4'd0;
                        BUSY       <= 1'b1;
                        stateReg   <= SEND;
                    end
                end
                SEND: begin
                    SEND_DATA       <= shiftReg[7:0];
                    SEND_DATA_READY <= 1'b1;
                    shiftReg        <= shiftReg >> 8;
                    byteCntReg      <= byteCntReg + 4'd1;
                    gapCntReg       <= '0;
                    stateReg        <= GAP;
                end
                GAP: begin
                    gapCntReg <= gapCntReg + GAP_W'(1);
                    if (gapCntReg == GAP_LAST) begin
                        if (byteCntReg == LAST_BYTE) begin
                            DONE0    <= ~ACTIVE_SRC;
                            DONE1    <= ACTIVE_SRC;
                            stateReg <= DONE;
                        end else begin
                            stateReg <= SEND;
                        end
                    end
                end
                DONE: begin
                    lastServedReg <= ACTIVE_SRC;
                    BUSY          <= 1'b0;
                    stateReg      <= IDLE;
                end
            endcase
        end
    end

endmodule
